// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
//   elev_state_e : car FSM states
//   DIR_UP/DOWN  : encoding of the dir output
package elevator_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} elev_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational call scan relative to a floor.
//   pending : latched call bitmask
//   floor   : reference floor
//   above   : any call strictly above floor
//   below   : any call strictly below floor
//   hit     : call pending at floor itself
module elevator_req_scan #(
  parameter int N_FLOORS = 4,
  localparam int FLOOR_W = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  floor,
  output logic                above,
  output logic                below,
  output logic                hit
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor) above = above | pending[i];
      if (FLOOR_W'(i) < floor) below = below | pending[i];
    end
  end

  assign hit = pending[floor];

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-ordered elevator car controller.
//   clk, rst       : clock, synchronous active-low reset
//   stop           : emergency hold (car/timer/state frozen, calls still latch)
//   req            : call bits, OR'd into pending every cycle
//   floor, dir     : current floor, travel direction (1=up)
//   moving         : car between floors
//   door_open      : door dwell in progress
//   pending        : latched unserved calls
//   changes_count  : floor changes since reset (wrapping)
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int TRAVEL_CYC = 2,
  parameter int DOOR_CYC   = 3,
  parameter int CNT_W      = 4,
  localparam int FLOOR_W   = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stop,
  input  logic [N_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]  floor,
  output logic                dir,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic [CNT_W-1:0]    changes_count
);

  localparam int TMR_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TRAVEL_RLD = TMR_W'(TRAVEL_CYC - 1);
  localparam logic [TMR_W-1:0] DOOR_RLD   = TMR_W'(DOOR_CYC - 1);

  elev_state_e          state;
  logic [TMR_W-1:0]     timer;
  logic [FLOOR_W-1:0]   nxt_floor;
  logic [N_FLOORS-1:0]  clr;
  logic                 above_cur, below_cur, hit_cur;
  logic                 above_nxt, below_nxt, hit_nxt;

  function automatic logic [N_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    onehot    = '0;
    onehot[f] = 1'b1;
  endfunction

  // Floor the car lands on when the current travel leg completes.
  assign nxt_floor = dir ? floor + 1'b1 : floor - 1'b1;

  // Scan around the current floor (idle decisions) and the arrival floor
  // (decision taken on the same edge the car lands).
  elevator_req_scan #(.N_FLOORS(N_FLOORS)) u_scan_cur (
    .pending (pending),
    .floor   (floor),
    .above   (above_cur),
    .below   (below_cur),
    .hit     (hit_cur)
  );

  elevator_req_scan #(.N_FLOORS(N_FLOORS)) u_scan_nxt (
    .pending (pending),
    .floor   (nxt_floor),
    .above   (above_nxt),
    .below   (below_nxt),
    .hit     (hit_nxt)
  );

  // Bit of the call being served this cycle. While the door is open, calls
  // for this floor are swallowed regardless of stop so they never re-latch.
  always_comb begin
    clr = '0;
    if (!stop) begin
      case (state)
        ST_IDLE: if (hit_cur) clr = onehot(floor);
        ST_MOVE: if (timer == '0 && hit_nxt) clr = onehot(nxt_floor);
        default: ;
      endcase
    end
    if (state == ST_DOOR) clr = onehot(floor);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      floor         <= '0;
      dir           <= DIR_UP;
      timer         <= '0;
      pending       <= '0;
      changes_count <= '0;
    end else begin
      pending <= (pending | req) & ~clr;
      if (!stop) begin
        unique case (state)
          ST_IDLE: begin
            if (hit_cur) begin
              state <= ST_DOOR;
              timer <= DOOR_RLD;
            end else if (above_cur && (dir || !below_cur)) begin
              dir   <= DIR_UP;
              state <= ST_MOVE;
              timer <= TRAVEL_RLD;
            end else if (below_cur) begin
              dir   <= DIR_DOWN;
              state <= ST_MOVE;
              timer <= TRAVEL_RLD;
            end
          end
          ST_MOVE: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              floor         <= nxt_floor;
              changes_count <= changes_count + 1'b1;
              if (hit_nxt) begin
                state <= ST_DOOR;
                timer <= DOOR_RLD;
              end else if (dir ? above_nxt : below_nxt) begin
                timer <= TRAVEL_RLD;
              end else if (dir ? below_nxt : above_nxt) begin
                dir   <= ~dir;
                timer <= TRAVEL_RLD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DOOR: begin
            if (timer == '0) state <= ST_IDLE;
            else             timer <= timer - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign moving    = (state == ST_MOVE);
  assign door_open = (state == ST_DOOR);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] floor;
  logic       dir, moving, door_open;
  logic [3:0] pending;
  logic [3:0] changes_count;

  int checks = 0;
  int passed = 0;

  elevator_scan_ctrl #(.N_FLOORS(4), .TRAVEL_CYC(2), .DOOR_CYC(3), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stop          (stop),
    .req           (req),
    .floor         (floor),
    .dir           (dir),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending),
    .changes_count (changes_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_door(input int max, output int n);
    n = 0;
    while (door_open !== 1'b1 && n < max) begin step(); n++; end
    checks++;
    if (door_open !== 1'b1) $display("FAIL wait_door timeout: door_open=%b required 1", door_open);
    else passed++;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((moving !== 1'b0 || door_open !== 1'b0) && n < max) begin step(); n++; end
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0)
      $display("FAIL wait_idle timeout: moving=%b door_open=%b required 0 0", moving, door_open);
    else passed++;
  endtask

  task automatic trip(input int target);
    int n;
    req = '0;
    req[target] = 1'b1;
    step();
    req = '0;
    wait_door(20, n);
    wait_idle(20);
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111;
    step(); step();
    checks++;
    if ({floor, pending, changes_count, moving, door_open, dir} !== {2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: floor=%0d pending=%b cnt=%0d mv=%b door=%b dir=%b required 0 0000 0 0 0 1",
               floor, pending, changes_count, moving, door_open, dir);
    else passed++;
    rst = 1'b1; req = '0;
    step();
    checks++;
    if (pending !== 4'b0000 || moving !== 1'b0) $display("FAIL reset_release: pending=%b moving=%b required 0000 0", pending, moving);
    else passed++;
  endtask

  task automatic test_up_trip();
    int n;
    req = 4'b1000; step(); req = '0;
    step();
    checks++;
    if (moving !== 1'b1) $display("FAIL up_move_entry: moving=%b required 1", moving); else passed++;
    step(); step();
    checks++;
    if (floor !== 2'd1) $display("FAIL up_floor1: floor=%0d required 1", floor); else passed++;
    step(); step();
    checks++;
    if (floor !== 2'd2) $display("FAIL up_floor2: floor=%0d required 2", floor); else passed++;
    step(); step();
    checks++;
    if (floor !== 2'd3 || door_open !== 1'b1) $display("FAIL up_arrive3: floor=%0d door=%b required 3 1", floor, door_open);
    else passed++;
    n = 0;
    while (door_open === 1'b1 && n < 10) begin n++; step(); end
    checks++;
    if (n !== 3) $display("FAIL up_door_dwell: cycles=%0d required 3", n); else passed++;
    checks++;
    if (changes_count !== 4'd3 || pending !== 4'b0000 || moving !== 1'b0)
      $display("FAIL up_done: cnt=%0d pending=%b moving=%b required 3 0000 0", changes_count, pending, moving);
    else passed++;
  endtask

  task automatic test_down_two_stops();
    int n;
    req = 4'b0101; step(); req = '0;
    wait_door(20, n);
    checks++;
    if (n !== 3 || floor !== 2'd2 || dir !== 1'b0)
      $display("FAIL down_stop2: cycles=%0d floor=%0d dir=%b required 3 2 0", n, floor, dir);
    else passed++;
    wait_idle(20);
    wait_door(20, n);
    checks++;
    if (floor !== 2'd0) $display("FAIL down_stop0: floor=%0d required 0", floor); else passed++;
    wait_idle(20);
    checks++;
    if (changes_count !== 4'd6 || pending !== 4'b0000)
      $display("FAIL down_done: cnt=%0d pending=%b required 6 0000", changes_count, pending);
    else passed++;
  endtask

  task automatic test_reverse();
    int n;
    req = 4'b1000; step(); req = '0;
    n = 0;
    while (floor !== 2'd2 && n < 20) begin step(); n++; end
    req = 4'b0001; step(); req = '0;
    wait_door(20, n);
    checks++;
    if (floor !== 2'd3 || pending !== 4'b0001)
      $display("FAIL reverse_first: floor=%0d pending=%b required 3 0001", floor, pending);
    else passed++;
    wait_idle(20);
    wait_door(20, n);
    checks++;
    if (floor !== 2'd0 || dir !== 1'b0 || changes_count !== 4'd12)
      $display("FAIL reverse_second: floor=%0d dir=%b cnt=%0d required 0 0 12", floor, dir, changes_count);
    else passed++;
    wait_idle(20);
  endtask

  task automatic test_stop();
    int n;
    req = 4'b0100; step(); req = '0;
    step();
    stop = 1'b1; req = 4'b0010;
    step(); step(); step();
    checks++;
    if (floor !== 2'd0 || moving !== 1'b1 || pending !== 4'b0110)
      $display("FAIL stop_frozen: floor=%0d moving=%b pending=%b required 0 1 0110", floor, moving, pending);
    else passed++;
    stop = 1'b0; req = '0;
    n = 0;
    while (floor !== 2'd1 && n < 10) begin step(); n++; end
    checks++;
    if (n !== 2 || door_open !== 1'b1)
      $display("FAIL stop_resume: cycles=%0d door=%b required 2 1", n, door_open);
    else passed++;
    wait_idle(20);
    wait_door(20, n);
    checks++;
    if (floor !== 2'd2 || changes_count !== 4'd14)
      $display("FAIL stop_final: floor=%0d cnt=%0d required 2 14", floor, changes_count);
    else passed++;
    wait_idle(20);
  endtask

  task automatic test_wrap_and_reset();
    int n;
    rst = 1'b0; step(); rst = 1'b1;
    trip(3); trip(0); trip(3); trip(0); trip(3);
    checks++;
    if (changes_count !== 4'd15) $display("FAIL wrap_pre: cnt=%0d required 15", changes_count); else passed++;
    req = 4'b0001; step(); req = '0;
    n = 0;
    while (floor !== 2'd2 && n < 20) begin step(); n++; end
    checks++;
    if (changes_count !== 4'd0 || moving !== 1'b1)
      $display("FAIL wrap: cnt=%0d moving=%b required 0 1", changes_count, moving);
    else passed++;
    rst = 1'b0; stop = 1'b1;
    step();
    checks++;
    if ({floor, moving, door_open, pending, changes_count, dir} !== {2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1})
      $display("FAIL reset_mid_move: floor=%0d mv=%b door=%b pending=%b cnt=%0d dir=%b required 0 0 0 0000 0 1",
               floor, moving, door_open, pending, changes_count, dir);
    else passed++;
    rst = 1'b1; stop = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_up_trip();
    test_down_two_stops();
    test_reverse();
    test_stop();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
